// File: rtl/mmu_psum_drain_pkg.sv
// Shared widths, FSM encoding and saturation helpers for the MMU partial-sum drain stage.
package mmu_psum_drain_pkg;

   localparam int DEF_LANES  = 16;
   localparam int DEF_ACC_W  = 24;
   localparam int DEF_PSUM_W = 32;
   localparam int DEF_BIT_W  = 8;
   localparam int DEF_ROWS   = 128;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_FILL  = 2'd1;
   localparam state_t ST_DRAIN = 2'd2;

   typedef struct packed {
      logic               sat;
      logic signed [63:0] val;
   } sat_res_t;

   // Widths up to 32 bits are handled in a 64-bit signed domain, so the raw sum never wraps.
   function automatic sat_res_t sat_to(input logic signed [63:0] v, input int w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      sat_res_t           r;
      hi    = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo    = -hi - 64'sd1;
      r.sat = (v > hi) || (v < lo);
      r.val = (v > hi) ? hi : ((v < lo) ? lo : v);
      return r;
   endfunction

   function automatic sat_res_t sat_add(input logic signed [63:0] a, input logic signed [63:0] b,
                                        input int w);
      return sat_to(a + b, w);
   endfunction

   function automatic sat_res_t clamp_to(input logic signed [63:0] v, input int w);
      return sat_to(v, w);
   endfunction

endpackage

// File: rtl/mmu_psum_drain_requant.sv
// One lane of the requantiser: round, arithmetic shift, clamp to BIT_W.
// MMU_PSUM_DRAIN_RELU_EN forces negative partial sums to zero before rounding.
module mmu_requant_lane
   import mmu_psum_drain_pkg::*;
#(
   parameter int PSUM_W = DEF_PSUM_W,
   parameter int BIT_W  = DEF_BIT_W
) (
   input  logic signed [PSUM_W-1:0] psum,
   input  logic        [4:0]        shift,
   output logic signed [BIT_W-1:0]  q,
   output logic                     sat
);

   logic signed [63:0] p_ext;
   logic signed [63:0] rnd;
   logic signed [63:0] shifted;
   sat_res_t           t_r;
   sat_res_t           c_r;

   // NOTE: every variable written here gets a value on every path, so no latch is inferred.
   always_comb begin
      p_ext = 64'(psum);
`ifdef MMU_PSUM_DRAIN_RELU_EN
      if (psum < 0) p_ext = 64'sd0;
`endif
      rnd     = (shift != 5'd0) ? (64'sd1 <<< (shift - 5'd1)) : 64'sd0;
      t_r     = sat_add(p_ext, rnd, PSUM_W);
      shifted = $signed(t_r.val) >>> shift;
      c_r     = clamp_to(shifted, BIT_W);
      q       = c_r.val[BIT_W-1:0];
      sat     = t_r.sat | c_r.sat;
   end

endmodule

// File: rtl/mmu_psum_drain.sv
// Accumulates K tiles of MMU rows in a row buffer, then requantises and drains them.
// Build option: MMU_PSUM_DRAIN_RELU_EN (see mmu_requant_lane).
module mmu_psum_drain
   import mmu_psum_drain_pkg::*;
#(
   parameter int LANES  = DEF_LANES,
   parameter int ACC_W  = DEF_ACC_W,
   parameter int PSUM_W = DEF_PSUM_W,
   parameter int BIT_W  = DEF_BIT_W,
   parameter int ROWS   = DEF_ROWS
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [7:0]               cfg_ntiles,
   input  logic [4:0]               cfg_shift,
   input  logic                     acc_vld,
   output logic                     acc_rdy,
   input  logic [LANES*ACC_W-1:0]   acc_data,
   output logic                     out_vld,
   input  logic                     out_rdy,
   output logic [LANES*BIT_W-1:0]   out_data,
   output logic                     out_last,
   output logic                     busy,
   output logic                     sat_flag
);

   localparam int            AW       = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam logic [AW-1:0] LAST_ROW = AW'(ROWS - 1);

   state_t                  state;
   logic [7:0]              tile_cnt;
   logic [7:0]              last_tile;
   logic [AW-1:0]           row_cnt;
   logic [4:0]              shift_q;

   logic [LANES*PSUM_W-1:0] mem [ROWS];
   logic [LANES*PSUM_W-1:0] rd_data;
   logic [LANES*PSUM_W-1:0] wr_data;
   logic                    rd_en;
   logic [AW-1:0]           rd_addr;

   logic                    p_vld;
   logic                    p_first;
   logic [AW-1:0]           p_row;
   logic [LANES*ACC_W-1:0]  p_acc;
   logic                    wr_ovf;

   logic [AW-1:0]           dr_addr;
   logic                    issue_done;
   logic                    rd_vld;
   logic                    rd_last;
   logic                    drain_rd;
   logic                    out_load;
   logic [LANES*BIT_W-1:0]  q_row;
   logic [LANES-1:0]        q_sat;

   logic                    accept;
   logic                    fill_done;
   logic [7:0]              cfg_last;
   logic [7:0]              cur_tile;
   logic [7:0]              cur_last_tile;
   logic [AW-1:0]           cur_row;

   // The IDLE beat is row 0 of tile 0 and uses the live cfg, since nothing is latched yet.
   assign cfg_last      = (cfg_ntiles == 8'd0) ? 8'd0 : cfg_ntiles - 8'd1;
   assign accept        = acc_vld && acc_rdy;
   assign cur_tile      = (state == ST_IDLE) ? 8'd0 : tile_cnt;
   assign cur_row       = (state == ST_IDLE) ? '0 : row_cnt;
   assign cur_last_tile = (state == ST_IDLE) ? cfg_last : last_tile;
   assign fill_done     = accept && (cur_row == LAST_ROW) && (cur_tile == cur_last_tile);
   assign busy          = (state != ST_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         acc_rdy   <= 1'b0;
         tile_cnt  <= 8'd0;
         row_cnt   <= '0;
         last_tile <= 8'd0;
         shift_q   <= 5'd0;
      end else begin
         acc_rdy <= 1'b1;
         if (accept) begin
            if (state == ST_IDLE) begin
               last_tile <= cfg_last;
               shift_q   <= cfg_shift;
            end
            if (fill_done) begin
               state    <= ST_DRAIN;
               acc_rdy  <= 1'b0;
               tile_cnt <= 8'd0;
               row_cnt  <= '0;
            end else begin
               state    <= ST_FILL;
               row_cnt  <= cur_row + 1'b1;
               tile_cnt <= (cur_row == LAST_ROW) ? cur_tile + 8'd1 : cur_tile;
            end
         end else if (state == ST_DRAIN) begin
            if (out_vld && out_rdy && out_last) state   <= ST_IDLE;
            else                                acc_rdy <= 1'b0;
         end
      end
   end

   // Read-modify-write: the accepted beat waits one cycle for its buffer row to be read.
   always_ff @(posedge clk) begin
      if (rst) p_vld <= 1'b0;
      else     p_vld <= accept;
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         p_row   <= cur_row;
         p_acc   <= acc_data;
         p_first <= (cur_tile == 8'd0);
      end
   end

   always_comb begin
      wr_data = '0;
      wr_ovf  = 1'b0;
      for (int l = 0; l < LANES; l++) begin : g_add
         logic signed [63:0] a;
         sat_res_t           r;
         a = 64'($signed(p_acc[l*ACC_W +: ACC_W]));
         r = sat_add(64'($signed(rd_data[l*PSUM_W +: PSUM_W])), a, PSUM_W);
         if (p_first) begin
            wr_data[l*PSUM_W +: PSUM_W] = a[PSUM_W-1:0];
         end else begin
            wr_data[l*PSUM_W +: PSUM_W] = r.val[PSUM_W-1:0];
            wr_ovf                      = wr_ovf | r.sat;
         end
      end
   end

   assign drain_rd = (state == ST_DRAIN) && !issue_done && (!rd_vld || out_load);
   assign out_load = rd_vld && (!out_vld || out_rdy);
   assign rd_en    = accept || drain_rd;
   assign rd_addr  = accept ? cur_row : dr_addr;

   // NOTE: the row buffer has no reset; tile 0 of each block overwrites a row before it is ever read back.
   always_ff @(posedge clk) begin
      if (p_vld) mem[p_row] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      mmu_requant_lane #(
         .PSUM_W (PSUM_W),
         .BIT_W  (BIT_W)
      ) u_lane (
         .psum  (rd_data[l*PSUM_W +: PSUM_W]),
         .shift (shift_q),
         .q     (q_row[l*BIT_W +: BIT_W]),
         .sat   (q_sat[l])
      );
   end

   // rd_vld/rd_data act as the prefetch slot in front of the output register.
   always_ff @(posedge clk) begin
      if (rst) begin
         dr_addr    <= '0;
         issue_done <= 1'b0;
         rd_vld     <= 1'b0;
         rd_last    <= 1'b0;
         out_vld    <= 1'b0;
         out_last   <= 1'b0;
         out_data   <= '0;
         sat_flag   <= 1'b0;
      end else begin
         if (fill_done) begin
            dr_addr    <= '0;
            issue_done <= 1'b0;
         end else if (drain_rd) begin
            dr_addr    <= dr_addr + 1'b1;
            issue_done <= (dr_addr == LAST_ROW);
         end

         if (drain_rd) begin
            rd_vld  <= 1'b1;
            rd_last <= (dr_addr == LAST_ROW);
         end else if (out_load) begin
            rd_vld  <= 1'b0;
         end

         if (out_load) begin
            out_vld  <= 1'b1;
            out_data <= q_row;
            out_last <= rd_last;
         end else if (out_vld && out_rdy) begin
            out_vld  <= 1'b0;
            out_last <= 1'b0;
         end

         sat_flag <= sat_flag | (p_vld & wr_ovf) | (out_load & (|q_sat));
      end
   end

endmodule

// File: tb/tb_mmu_psum_drain.sv
// Self-checking bench for mmu_psum_drain (PSUM_W=24 build so partial-sum overflow is reachable).
module tb_mmu_psum_drain;

   localparam int LANES  = 16;
   localparam int ACC_W  = 24;
   localparam int PSUM_W = 24;
   localparam int BIT_W  = 8;
   localparam int ROWS   = 128;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [7:0]             cfg_ntiles;
   logic [4:0]             cfg_shift;
   logic                   acc_vld;
   logic                   acc_rdy;
   logic [LANES*ACC_W-1:0] acc_data;
   logic                   out_vld;
   logic                   out_rdy;
   logic [LANES*BIT_W-1:0] out_data;
   logic                   out_last;
   logic                   busy;
   logic                   sat_flag;

   always #5 clk = ~clk;

   mmu_psum_drain #(
      .LANES (LANES), .ACC_W (ACC_W), .PSUM_W (PSUM_W), .BIT_W (BIT_W), .ROWS (ROWS)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_ntiles (cfg_ntiles),
      .cfg_shift  (cfg_shift),
      .acc_vld    (acc_vld),
      .acc_rdy    (acc_rdy),
      .acc_data   (acc_data),
      .out_vld    (out_vld),
      .out_rdy    (out_rdy),
      .out_data   (out_data),
      .out_last   (out_last),
      .busy       (busy),
      .sat_flag   (sat_flag)
   );

   int                     checks = 0;
   int                     errors = 0;
   longint                 mbuf     [ROWS][LANES];
   longint                 lane_val [LANES];
   bit                     rand_vals;
   bit                     sat_model;
   logic [LANES*BIT_W-1:0] exp_rows [ROWS];
   logic [LANES*BIT_W-1:0] first_row;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference arithmetic: saturate to a signed width and remember that it happened.
   function automatic longint clip(input longint v, input int w);
      longint hi = (longint'(1) <<< (w - 1)) - 1;
      longint lo = -(longint'(1) <<< (w - 1));
      if (v > hi) begin sat_model = 1'b1; return hi; end
      if (v < lo) begin sat_model = 1'b1; return lo; end
      return v;
   endfunction

   function automatic longint floor_div_pow2(input longint t, input int s);
      longint d = longint'(1) << s;
      longint q = t / d;
      if ((t % d != 0) && (t < 0)) q = q - 1;
      return q;
   endfunction

   function automatic longint requant(input longint p, input int s);
      longint t;
`ifdef MMU_PSUM_DRAIN_RELU_EN
      if (p < 0) p = 0;
`endif
      t = clip(p + ((s > 0) ? (longint'(1) << (s - 1)) : 0), PSUM_W);
      return clip(floor_div_pow2(t, s), BIT_W);
   endfunction

   function automatic longint rand_acc();
      if ($urandom_range(0, 3) == 0) return longint'($signed(ACC_W'($urandom)));
      return longint'($urandom_range(0, 2000)) - 1000;
   endfunction

   task automatic reset_checks();
      check("rst_acc_rdy",  acc_rdy,  1'b0);
      check("rst_out_vld",  out_vld,  1'b0);
      check("rst_out_data", out_data, '0);
      check("rst_out_last", out_last, 1'b0);
      check("rst_busy",     busy,     1'b0);
      check("rst_sat_flag", sat_flag, 1'b0);
   endtask

   // Streams nt tiles of rows; stops before beat (abort_tile, abort_row) if it is reached.
   task automatic fill_block(input int nt_cfg, input int sh, input bit bubbles,
                             input int abort_tile, input int abort_row);
      int                     eff = (nt_cfg == 0) ? 1 : nt_cfg;
      int                     waits;
      longint                 v;
      logic [LANES*ACC_W-1:0] beat;
      cfg_ntiles = 8'(nt_cfg);
      cfg_shift  = 5'(sh);
      for (int t = 0; t < eff; t++) begin
         for (int r = 0; r < ROWS; r++) begin
            if (t == abort_tile && r == abort_row) return;
            for (int l = 0; l < LANES; l++) begin
               v = rand_vals ? rand_acc() : lane_val[l];
               beat[l*ACC_W +: ACC_W] = ACC_W'(v);
               mbuf[r][l] = (t == 0) ? v : clip(mbuf[r][l] + v, PSUM_W);
            end
            @(negedge clk);
            if (t != 0 || r != 0) begin
               cfg_ntiles = 8'($urandom);
               cfg_shift  = 5'($urandom);
            end
            if (bubbles && $urandom_range(0, 3) == 0) begin
               acc_vld = 1'b0;
               @(negedge clk);
            end
            acc_vld  = 1'b1;
            acc_data = beat;
            waits    = 0;
            while (!acc_rdy && waits < 20) begin
               @(negedge clk);
               waits++;
            end
            check("acc_rdy_wait", acc_rdy, 1'b1);
            @(posedge clk);
         end
      end
   endtask

   // Called right after the final accepting edge; collects ROWS rows under the given out_rdy pattern.
   task automatic drain_block(input int sh, input int rdy_mode, input bit poke_acc);
      logic [LANES*BIT_W-1:0] snap;
      bit                     snap_last;
      bit                     sat_before;
      bit                     prev_stall;
      bit                     ready;
      int                     row;
      int                     cyc;
      sat_before = sat_model;
      for (int r = 0; r < ROWS; r++)
         for (int l = 0; l < LANES; l++)
            exp_rows[r][l*BIT_W +: BIT_W] = BIT_W'(requant(mbuf[r][l], sh));
      @(negedge clk);
      acc_vld = poke_acc;
      out_rdy = 1'b1;
      check("n1_out_vld", out_vld, 1'b0);
      check("n1_acc_rdy", acc_rdy, 1'b0);
      check("n1_busy",    busy,    1'b1);
      @(negedge clk);
      check("n2_out_vld",    out_vld,  1'b0);
      check("fill_sat_flag", sat_flag, sat_before);
      @(negedge clk);
      check("n3_out_vld", out_vld, 1'b1);
      row        = 0;
      cyc        = 0;
      prev_stall = 1'b0;
      snap       = '0;
      snap_last  = 1'b0;
      while (row < ROWS && cyc < 2000) begin
         if (prev_stall) check("stall_hold", {out_vld, out_last, out_data}, {1'b1, snap_last, snap});
         check("drain_acc_rdy", acc_rdy, 1'b0);
         case (rdy_mode)
            0:       ready = 1'b1;
            1:       ready = (cyc % 2 == 0);
            default: ready = 1'($urandom_range(0, 1));
         endcase
         out_rdy = ready;
         if (out_vld && ready) begin
            check("row_data", out_data, exp_rows[row]);
            check("row_last", out_last, 1'(row == ROWS - 1));
            if (row == 0) first_row = out_data;
            row++;
         end
         prev_stall = out_vld && !ready;
         snap       = out_data;
         snap_last  = out_last;
         if (poke_acc)
            for (int l = 0; l < LANES; l++) acc_data[l*ACC_W +: ACC_W] = ACC_W'($urandom);
         cyc++;
         @(negedge clk);
      end
      check("drain_rows", row, ROWS);
      out_rdy = 1'b0;
      acc_vld = 1'b0;
      check("end_acc_rdy",  acc_rdy,  1'b1);
      check("end_busy",     busy,     1'b0);
      check("end_out_vld",  out_vld,  1'b0);
      check("end_sat_flag", sat_flag, sat_model);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst        = 1'b1;
      acc_vld    = 1'b0;
      acc_data   = '0;
      out_rdy    = 1'b0;
      cfg_ntiles = 8'd0;
      cfg_shift  = 5'd0;
      sat_model  = 1'b0;
      rand_vals  = 1'b0;
      first_row  = '0;
      repeat (2) @(negedge clk);
      reset_checks();
      rst = 1'b0;

      // Single tile of constant 5s, no backpressure.
      foreach (lane_val[l]) lane_val[l] = 5;
      fill_block(1, 0, 1'b0, -1, -1);
      drain_block(0, 0, 1'b0);
      check("t1_row0", first_row, {LANES{8'd5}});

      // Three tiles, rounding shift of 2, mixed-sign lanes.
      foreach (lane_val[l]) lane_val[l] = 3;
      lane_val[0] = 7;
      lane_val[1] = -7;
      fill_block(3, 2, 1'b1, -1, -1);
      drain_block(2, 2, 1'b0);
      check("t2_lane0", first_row[7:0], 8'd5);
`ifdef MMU_PSUM_DRAIN_RELU_EN
      check("t2_lane1", first_row[15:8], 8'd0);
`else
      check("t2_lane1", first_row[15:8], 8'hFB);
`endif
      check("t2_lane2", first_row[23:16], 8'd2);

      // Output clamp in both directions.
      foreach (lane_val[l]) lane_val[l] = (l % 2 == 0) ? 300 : -300;
      fill_block(1, 0, 1'b0, -1, -1);
      drain_block(0, 2, 1'b0);
      check("t3_lane0", first_row[7:0], 8'h7F);
`ifdef MMU_PSUM_DRAIN_RELU_EN
      check("t3_lane1", first_row[15:8], 8'h00);
`else
      check("t3_lane1", first_row[15:8], 8'h80);
`endif
      check("t3_sat", sat_flag, 1'b1);

      // Random data, alternating out_rdy, acc_vld held high during the drain.
      rand_vals = 1'b1;
      begin
         int sh = $urandom_range(0, 31);
         fill_block(2, sh, 1'b1, -1, -1);
         drain_block(sh, 1, 1'b1);
      end

      // Abort mid-fill, then a clean single tile of 1s must show no stale sum.
      rand_vals = 1'b0;
      foreach (lane_val[l]) lane_val[l] = 50;
      fill_block(2, 0, 1'b0, 1, 60);
      @(negedge clk);
      rst     = 1'b1;
      acc_vld = 1'b0;
      @(negedge clk);
      reset_checks();
      rst       = 1'b0;
      sat_model = 1'b0;
      foreach (lane_val[l]) lane_val[l] = 1;
      fill_block(1, 0, 1'b0, -1, -1);
      drain_block(0, 2, 1'b0);
      check("t5_row0", first_row, {LANES{8'd1}});
      check("t5_sat",  sat_flag,  1'b0);

      // Partial-sum overflow: psum must hold at 2^23-1, giving 127 after >>>16.
      foreach (lane_val[l]) lane_val[l] = (longint'(1) << 23) - 1;
      fill_block(2, 16, 1'b0, -1, -1);
      drain_block(16, 0, 1'b0);
      check("t6_row0", first_row, {LANES{8'h7F}});
      check("t6_sat",  sat_flag,  1'b1);

      // Random blocks, including ntiles=0 treated as a single tile.
      rand_vals = 1'b1;
      for (int k = 0; k < 3; k++) begin
         int nt = (k == 0) ? 0 : $urandom_range(1, 3);
         int sh = $urandom_range(0, 31);
         fill_block(nt, sh, 1'b1, -1, -1);
         drain_block(sh, 2, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
